// File: rtl/ex_mc.sv
// ex_mc: OpenMIPS execute stage with logic/shift ALU and an iterative
// radix-2 multiplier (MULT/MULTU) that writes HI/LO.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   aluop_i, alusel_i operation code and result-group select
//   reg1_i, reg2_i    operands (shift: reg1_i low bits = amount, reg2_i = value)
//   wd_i, wreg_i      destination register and write enable, passed through
//   flush_i           aborts the in-flight instruction
//   wd_o, wreg_o      pass-through of wd_i / wreg_i
//   wdata_o           selected result
//   whilo_o           one-cycle HI/LO write strobe
//   hi_o, lo_o        upper / lower half of the product
//   stallreq_o        holds pc/if_id/id_ex while the multiplier is busy
// Every output is forced to zero while rst is high.
module ex_mc #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            aluop_i,
  input  logic [2:0]            alusel_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  whilo_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  stallreq_o
);

  localparam int unsigned SHAMT_W = $clog2(DATA_W);
  localparam int unsigned PROD_W  = 2 * DATA_W;
  localparam int unsigned CNT_W   = $clog2(DATA_W + 1);

  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MUL   = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic                sign_q, sign_d;

  logic [SHAMT_W-1:0]  shamt_c;
  logic [DATA_W-1:0]   logic_res_c;
  logic [DATA_W-1:0]   shift_res_c;
  logic [DATA_W-1:0]   abs1_c;
  logic [DATA_W-1:0]   abs2_c;
  logic [DATA_W-1:0]   addend_c;
  logic [DATA_W:0]     sum_c;
  logic [PROD_W-1:0]   prod_c;
  logic                is_mul_op_c;
  logic                stall_c;
  logic                whilo_c;

  // Logic unit: unlisted opcodes yield zero.
  always_comb begin
    logic_res_c = '0;
    unique case (aluop_i)
      OP_AND:  logic_res_c = reg1_i & reg2_i;
      OP_OR:   logic_res_c = reg1_i | reg2_i;
      OP_XOR:  logic_res_c = reg1_i ^ reg2_i;
      OP_NOR:  logic_res_c = ~(reg1_i | reg2_i);
      default: logic_res_c = '0;
    endcase
  end

  // Shift unit: value in reg2_i, amount in the low bits of reg1_i.
  always_comb begin
    shamt_c     = reg1_i[SHAMT_W-1:0];
    shift_res_c = '0;
    unique case (aluop_i)
      OP_SLL:  shift_res_c = reg2_i << shamt_c;
      OP_SRL:  shift_res_c = reg2_i >> shamt_c;
      OP_SRA:  shift_res_c = $signed(reg2_i) >>> shamt_c;
      default: shift_res_c = '0;
    endcase
  end

  // Operand magnitudes; the most negative value maps to itself, which is
  // exact when read back as unsigned.
  always_comb begin
    abs1_c = reg1_i[DATA_W-1] ? (~reg1_i + DATA_W'(1)) : reg1_i;
    abs2_c = reg2_i[DATA_W-1] ? (~reg2_i + DATA_W'(1)) : reg2_i;
  end

  // One partial-product step: add into the upper half, keep the carry so
  // the following right shift loses nothing.
  always_comb begin
    addend_c = mplier_q[0] ? mcand_q : '0;
    sum_c    = {1'b0, acc_q[PROD_W-1:DATA_W]} + {1'b0, addend_c};
    prod_c   = sign_q ? (~acc_q + PROD_W'(1)) : acc_q;
  end

  assign is_mul_op_c = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU);

  // Multiplier state register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
    end
  end

  // Multiplier next-state, datapath update and control strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    stall_c  = 1'b0;
    whilo_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (is_mul_op_c && !flush_i) begin
          stall_c = 1'b1;
          state_d = ST_BUSY;
          cnt_d   = '0;
          acc_d   = '0;
          if (aluop_i == OP_MULT) begin
            mcand_d  = abs1_c;
            mplier_d = abs2_c;
            sign_d   = reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1];
          end else begin
            mcand_d  = reg1_i;
            mplier_d = reg2_i;
            sign_d   = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        stall_c  = 1'b1;
        acc_d    = {sum_c, acc_q[DATA_W-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        whilo_c = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything, including a completing product.
    if (flush_i) begin
      state_d = ST_IDLE;
      stall_c = 1'b0;
      whilo_c = 1'b0;
    end
  end

  // Output mux, zeroed while reset is held.
  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      whilo_o    = whilo_c;
      stallreq_o = stall_c;
      if (whilo_c) begin
        hi_o = prod_c[PROD_W-1:DATA_W];
        lo_o = prod_c[DATA_W-1:0];
      end
      unique case (alusel_i)
        SEL_LOGIC: wdata_o = logic_res_c;
        SEL_SHIFT: wdata_o = shift_res_c;
        SEL_MUL:   wdata_o = whilo_c ? prod_c[DATA_W-1:0] : '0;
        default:   wdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mc.sv
// Testbench for ex_mc: directed and random stimulus, scoreboard queues
// filled at issue time, popped by a monitor on whilo_o / wreg_o.
module tb_ex_mc;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MUL   = 3'b101;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    aluop_i;
  logic [2:0]    alusel_i;
  logic [DW-1:0] reg1_i, reg2_i;
  logic [AW-1:0] wd_i;
  logic          wreg_i;
  logic          flush_i;
  logic [AW-1:0] wd_o;
  logic          wreg_o;
  logic [DW-1:0] wdata_o;
  logic          whilo_o;
  logic [DW-1:0] hi_o, lo_o;
  logic          stallreq_o;

  always #5 clk = ~clk;

  ex_mc #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [63:0] hilo_q[$];
  logic [36:0] wr_q[$];
  int          pulse_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
    int s;
    logic [31:0] r;
    s = int'(a[4:0]);
    r = 32'h0;
    if (sel == SEL_LOGIC) begin
      case (op)
        OP_AND:  r = a & b;
        OP_OR:   r = a | b;
        OP_XOR:  r = a ^ b;
        OP_NOR:  r = ~(a | b);
        default: r = 32'h0;
      endcase
    end else if (sel == SEL_SHIFT) begin
      case (op)
        OP_SLL:  r = b << s;
        OP_SRL:  r = b >> s;
        OP_SRA:  r = (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  // Reference product with 64-bit integer arithmetic.
  function automatic logic [63:0] ref_mul(input logic is_signed, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x, y;
    longint unsigned u;
    if (is_signed) begin
      x = $signed(a);
      y = $signed(b);
      return 64'(x * y);
    end
    u = {32'h0, a} * {32'h0, b};
    return u;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    cyc++;
    if (whilo_o !== 1'b0) begin
      if (hilo_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_whilo: got whilo_o=%b hi=%h lo=%h expected no pulse", whilo_o, hi_o, lo_o);
      end else begin
        chk("hilo", {hi_o, lo_o}, hilo_q.pop_front());
        pulse_cyc.push_back(cyc);
      end
    end
    if (wreg_o !== 1'b0) begin
      if (wr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_wreg: got wreg_o=%b wd=%h wdata=%h expected no write", wreg_o, wd_o, wdata_o);
      end else begin
        chk("wd_wdata", 64'({wd_o, wdata_o}), 64'(wr_q.pop_front()));
      end
    end
  end

  // Presents one instruction and holds it while stallreq_o is high.
  task automatic issue(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wr,
                       input string name);
    logic is_mul;
    int n;
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    n = 0;
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr;
    if (is_mul) hilo_q.push_back(ref_mul(op == OP_MULT, a, b));
    if (wr) wr_q.push_back({wd, ref_alu(op, sel, a, b)});
    forever begin
      @(negedge clk);
      if (stallreq_o !== 1'b1) break;
      n++;
      if (n > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_timeout: got stall >200 cycles expected %0d", name, DW + 1);
        break;
      end
      @(posedge clk); #1;
      // latched operands must be used, so scramble the live inputs
      if (is_mul) begin reg1_i = $urandom; reg2_i = $urandom; end
    end
    chk({name, "_stall_cycles"}, 64'(n), is_mul ? 64'(DW + 1) : 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic go_idle();
    aluop_i = 8'h00; alusel_i = 3'b000; wreg_i = 1'b0; flush_i = 1'b0;
  endtask

  // Abort a MULT 7 x -3 in its 10th BUSY cycle, by flush or by reset.
  task automatic abort_test(input logic use_rst);
    aluop_i = OP_MULT; alusel_i = SEL_MUL; reg1_i = 32'd7; reg2_i = 32'hFFFF_FFFD;
    wreg_i = 1'b0; wd_i = 5'd0;
    @(negedge clk);
    chk("abort_start_stall", 64'(stallreq_o), 64'd1);
    repeat (10) begin @(posedge clk); #1; end
    if (use_rst) begin
      rst = 1'b1; aluop_i = OP_OR; alusel_i = SEL_LOGIC;
      reg1_i = 32'hF0F0_F0F0; reg2_i = 32'h0F0F_0F0F; wd_i = 5'h1F; wreg_i = 1'b1;
    end else begin
      flush_i = 1'b1;
    end
    @(negedge clk);
    chk("abort_stall", 64'(stallreq_o), 64'd0);
    chk("abort_whilo", 64'(whilo_o), 64'd0);
    if (use_rst) begin
      chk("rst_wd", 64'(wd_o), 64'd0);
      chk("rst_wreg", 64'(wreg_o), 64'd0);
      chk("rst_wdata", 64'(wdata_o), 64'd0);
      chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    go_idle();
    repeat (40) @(negedge clk);
    chk("abort_idle_stall", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int gap;
    logic [7:0] op;
    logic [2:0] sel;
    rst = 1'b1; flush_i = 1'b0;
    aluop_i = OP_OR; alusel_i = SEL_LOGIC; reg1_i = 32'hF0F0_0000; reg2_i = 32'h0000_0F0F;
    wd_i = 5'd3; wreg_i = 1'b1;
    @(negedge clk);
    chk("reset_wd", 64'(wd_o), 64'd0);
    chk("reset_wreg", 64'(wreg_o), 64'd0);
    chk("reset_wdata", 64'(wdata_o), 64'd0);
    chk("reset_hilo", {hi_o, lo_o}, 64'd0);
    @(posedge clk); #1;
    aluop_i = OP_MULT; alusel_i = SEL_MUL;
    @(negedge clk);
    chk("reset_stall", 64'(stallreq_o), 64'd0);
    chk("reset_whilo", 64'(whilo_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    go_idle();
    @(posedge clk); #1;

    // Logic and shift
    issue(OP_OR,  SEL_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, 5'd1, 1'b1, "or");
    issue(OP_SRA, SEL_SHIFT, 32'd5, 32'h8000_0000, 5'd2, 1'b1, "sra");
    issue(OP_SRL, SEL_SHIFT, 32'd5, 32'h8000_0000, 5'd3, 1'b1, "srl");
    issue(OP_SLL, SEL_SHIFT, 32'hFFFF_FFFF, 32'h0000_0003, 5'd4, 1'b1, "sll31");
    issue(OP_NOR, SEL_LOGIC, 32'h1234_5678, 32'h0F0F_0000, 5'd5, 1'b1, "nor");
    issue(OP_AND, SEL_SHIFT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1, "and_badsel");
    issue(8'h55,  SEL_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1, "badop");

    // Multiplier corners
    issue(OP_MULT,  SEL_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0, "mult_m1");
    issue(OP_MULTU, SEL_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0, "multu_max");
    issue(OP_MULT,  SEL_MUL, 32'h8000_0000, 32'h8000_0000, 5'd0, 1'b0, "mult_min");
    issue(OP_MULT,  SEL_MUL, 32'h8000_0000, 32'h0000_0001, 5'd0, 1'b0, "mult_minx1");

    abort_test(1'b0);
    abort_test(1'b1);
    issue(OP_MULT, SEL_MUL, 32'd7, 32'hFFFF_FFFD, 5'd0, 1'b0, "mult_after_abort");

    // Flush coinciding with DONE
    aluop_i = OP_MULT; alusel_i = SEL_MUL; reg1_i = 32'd5; reg2_i = 32'd6; wreg_i = 1'b0;
    repeat (DW + 1) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_done_whilo", 64'(whilo_o), 64'd0);
    chk("flush_done_hilo", {hi_o, lo_o}, 64'd0);
    @(posedge clk); #1;
    go_idle();

    // Flush while a MULT is presented in IDLE: no start
    aluop_i = OP_MULTU; alusel_i = SEL_MUL; flush_i = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    go_idle();
    @(negedge clk);
    chk("flush_idle_nostart", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;

    // Back-to-back MULTs
    pulse_cyc.delete();
    issue(OP_MULT, SEL_MUL, 32'd3, 32'd4, 5'd0, 1'b0, "b2b_a");
    issue(OP_MULT, SEL_MUL, 32'hFFFF_FFFE, 32'd5, 5'd0, 1'b0, "b2b_b");
    chk("b2b_pulses", 64'(pulse_cyc.size()), 64'd2);
    if (pulse_cyc.size() == 2) begin
      gap = pulse_cyc[1] - pulse_cyc[0];
      chk("b2b_gap", 64'(gap), 64'(DW + 2));
    end

    // Random mix
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [31:0] a, b;
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 5))
        0: a = 32'h0; 1: a = 32'h8000_0000; 2: a = 32'hFFFF_FFFF; default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0; 1: b = 32'h7FFF_FFFF; 2: b = 32'hFFFF_FFFF; default: b = $urandom;
      endcase
      if (r < 2) begin
        issue((r == 0) ? OP_MULT : OP_MULTU, SEL_MUL, a, b, 5'd0, 1'b0, "rnd_mul");
      end else begin
        case ($urandom_range(0, 8))
          0: op = OP_AND; 1: op = OP_OR; 2: op = OP_XOR; 3: op = OP_NOR;
          4: op = OP_SLL; 5: op = OP_SRL; 6: op = OP_SRA; 7: op = 8'h00;
          default: op = 8'hA5;
        endcase
        case ($urandom_range(0, 4))
          0, 1: sel = SEL_LOGIC; 2, 3: sel = SEL_SHIFT; default: sel = 3'b111;
        endcase
        issue(op, sel, a, b, 5'($urandom), 1'b1, "rnd_alu");
      end
    end

    go_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("hilo_q_drained", 64'(hilo_q.size()), 64'd0);
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
